// File: rtl/yolov4_param_loader_pkg.sv
// Shared encodings for the parameter loader: layer-FSM state codes,
// loader FSM states and the buffer target select.
package yolov4_param_loader_pkg;

  localparam int ST_W = 4;

  localparam logic [ST_W-1:0] IDLE           = 4'd0;
  localparam logic [ST_W-1:0] RECEIVE_SCALE  = 4'd1;
  localparam logic [ST_W-1:0] RECEIVE_WEIGHT = 4'd2;
  localparam logic [ST_W-1:0] RECEIVE_BIAS   = 4'd3;
  localparam logic [ST_W-1:0] CONV_STATE     = 4'd4;
  localparam logic [ST_W-1:0] MAX_POOL_STATE = 4'd5;
  localparam logic [ST_W-1:0] UPSAMPLE_STATE = 4'd6;
  localparam logic [ST_W-1:0] ROUTE_STATE    = 4'd7;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_DONE = 2'd2
  } ld_state_e;

  typedef enum logic [1:0] {
    TGT_NONE   = 2'd0,
    TGT_SCALE  = 2'd1,
    TGT_WEIGHT = 2'd2,
    TGT_BIAS   = 2'd3
  } tgt_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/yolov4_seg_counter.sv
// Loadable up-counter with terminal-count compare; exposes its low bits
// as the buffer write address.
module yolov4_seg_counter
  import yolov4_param_loader_pkg::*;
#(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-2:0] addr,
  output logic         at_term
);

  logic [W-1:0] cnt_r;

  // count register: load takes priority over increment
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (inc) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign addr    = cnt_r[W-2:0];
  assign at_term = (cnt_r == term);

endmodule

// File: rtl/yolov4_param_loader.sv
// Streams scale/weight/bias words into their on-chip buffers while the layer
// FSM sits in the matching RECEIVE state; signals completion and framing errors.
module yolov4_param_loader
  import yolov4_param_loader_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SADDR_W = 8,
  parameter int WADDR_W = 12,
  parameter int BADDR_W = 8,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [STATE_W-1:0] state,
  input  logic [SADDR_W:0]   cfg_scale_len,
  input  logic [WADDR_W:0]   cfg_weight_len,
  input  logic [BADDR_W:0]   cfg_bias_len,
  input  logic               s_valid,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_last,
  output logic               s_ready,
  output logic               scale_we,
  output logic [SADDR_W-1:0] scale_addr,
  output logic               weight_we,
  output logic [WADDR_W-1:0] weight_addr,
  output logic               bias_we,
  output logic [BADDR_W-1:0] bias_addr,
  output logic [DATA_W-1:0]  buf_wdata,
  output logic               load_done,
  output logic               load_err
);

  localparam int CNT_W = max3(SADDR_W, WADDR_W, BADDR_W) + 1;

  ld_state_e          lst_r;
  tgt_e               tgt_r;
  tgt_e               code_tgt_s;
  logic [STATE_W-1:0] prev_state_r;
  logic [CNT_W-1:0]   len_r;
  logic [CNT_W-1:0]   cfg_len_s;
  logic [CNT_W-1:0]   term_s;
  logic [CNT_W-2:0]   addr_s;
  logic               is_recv_s;
  logic               seg_start_s;
  logic               match_s;
  logic               s_ready_s;
  logic               hs_s;
  logic               last_s;

  logic               scale_we_r;
  logic               weight_we_r;
  logic               bias_we_r;
  logic [SADDR_W-1:0] scale_addr_r;
  logic [WADDR_W-1:0] weight_addr_r;
  logic [BADDR_W-1:0] bias_addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               load_done_r;
  logic               load_err_r;

  // decode the layer-FSM state into a buffer target and its configured length
  always_comb begin
    is_recv_s  = 1'b0;
    code_tgt_s = TGT_NONE;
    cfg_len_s  = {CNT_W{1'b0}};
    case (state)
      STATE_W'(RECEIVE_SCALE): begin
        is_recv_s  = 1'b1;
        code_tgt_s = TGT_SCALE;
        cfg_len_s  = CNT_W'(cfg_scale_len);
      end
      STATE_W'(RECEIVE_WEIGHT): begin
        is_recv_s  = 1'b1;
        code_tgt_s = TGT_WEIGHT;
        cfg_len_s  = CNT_W'(cfg_weight_len);
      end
      STATE_W'(RECEIVE_BIAS): begin
        is_recv_s  = 1'b1;
        code_tgt_s = TGT_BIAS;
        cfg_len_s  = CNT_W'(cfg_bias_len);
      end
      default: begin
        is_recv_s  = 1'b0;
        code_tgt_s = TGT_NONE;
        cfg_len_s  = {CNT_W{1'b0}};
      end
    endcase
  end

  // ready is gated by the live state so a word offered during a switch is dropped
  assign seg_start_s = is_recv_s && (state != prev_state_r);
  assign match_s     = is_recv_s && (code_tgt_s == tgt_r);
  assign s_ready_s   = (lst_r == L_LOAD) && match_s && !seg_start_s;
  assign hs_s        = s_valid && s_ready_s;
  assign term_s      = len_r - {{(CNT_W-1){1'b0}}, 1'b1};

  yolov4_seg_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (seg_start_s),
    .load_val ({CNT_W{1'b0}}),
    .inc      (hs_s),
    .term     (term_s),
    .addr     (addr_s),
    .at_term  (last_s)
  );

  // loader FSM with registered buffer-write, done and error outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lst_r         <= L_IDLE;
      tgt_r         <= TGT_NONE;
      prev_state_r  <= {STATE_W{1'b0}};
      len_r         <= {CNT_W{1'b0}};
      scale_we_r    <= 1'b0;
      weight_we_r   <= 1'b0;
      bias_we_r     <= 1'b0;
      scale_addr_r  <= {SADDR_W{1'b0}};
      weight_addr_r <= {WADDR_W{1'b0}};
      bias_addr_r   <= {BADDR_W{1'b0}};
      wdata_r       <= {DATA_W{1'b0}};
      load_done_r   <= 1'b0;
      load_err_r    <= 1'b0;
    end else begin
      prev_state_r <= state;
      scale_we_r   <= 1'b0;
      weight_we_r  <= 1'b0;
      bias_we_r    <= 1'b0;
      load_done_r  <= 1'b0;

      if (state == STATE_W'(IDLE)) begin
        load_err_r <= 1'b0;
      end else if (hs_s && (s_last != last_s)) begin
        load_err_r <= 1'b1;
      end else begin
        load_err_r <= load_err_r;
      end

      if (hs_s) begin
        wdata_r <= s_data;
        case (tgt_r)
          TGT_SCALE: begin
            scale_we_r   <= 1'b1;
            scale_addr_r <= addr_s[SADDR_W-1:0];
          end
          TGT_WEIGHT: begin
            weight_we_r   <= 1'b1;
            weight_addr_r <= addr_s[WADDR_W-1:0];
          end
          TGT_BIAS: begin
            bias_we_r   <= 1'b1;
            bias_addr_r <= addr_s[BADDR_W-1:0];
          end
          default: begin
            wdata_r <= s_data;
          end
        endcase
      end

      if (seg_start_s) begin
        tgt_r <= code_tgt_s;
        len_r <= cfg_len_s;
        if (cfg_len_s == {CNT_W{1'b0}}) begin
          lst_r       <= L_DONE;
          load_done_r <= 1'b1;
        end else begin
          lst_r <= L_LOAD;
        end
      end else begin
        case (lst_r)
          L_IDLE: lst_r <= L_IDLE;
          L_LOAD: begin
            if (!match_s) begin
              lst_r <= L_IDLE;
            end else if (hs_s && last_s) begin
              lst_r       <= L_DONE;
              load_done_r <= 1'b1;
            end else begin
              lst_r <= L_LOAD;
            end
          end
          L_DONE:  lst_r <= L_IDLE;
          default: lst_r <= L_IDLE;
        endcase
      end
    end
  end

  assign s_ready     = s_ready_s;
  assign scale_we    = scale_we_r;
  assign weight_we   = weight_we_r;
  assign bias_we     = bias_we_r;
  assign scale_addr  = scale_addr_r;
  assign weight_addr = weight_addr_r;
  assign bias_addr   = bias_addr_r;
  assign buf_wdata   = wdata_r;
  assign load_done   = load_done_r;
  assign load_err    = load_err_r;

endmodule

// File: tb/tb_yolov4_param_loader.sv
// Scoreboard bench for yolov4_param_loader: expected buffer writes are queued
// as words are offered and popped when a write enable appears.
module tb_yolov4_param_loader;
  import yolov4_param_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  state;
  logic [8:0]  cfg_scale_len;
  logic [12:0] cfg_weight_len;
  logic [8:0]  cfg_bias_len;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_ready;
  logic        scale_we;
  logic [7:0]  scale_addr;
  logic        weight_we;
  logic [11:0] weight_addr;
  logic        bias_we;
  logic [7:0]  bias_addr;
  logic [31:0] buf_wdata;
  logic        load_done;
  logic        load_err;

  typedef struct {
    logic [2:0]  we;
    logic [12:0] addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  done_cnt = 0;
  int  exp_done = 0;
  logic lone_done_exp = 1'b0;

  localparam logic [2:0] WE_S = 3'b100;
  localparam logic [2:0] WE_W = 3'b010;
  localparam logic [2:0] WE_B = 3'b001;

  yolov4_param_loader dut (
    .clk(clk), .rstn(rstn), .state(state),
    .cfg_scale_len(cfg_scale_len), .cfg_weight_len(cfg_weight_len), .cfg_bias_len(cfg_bias_len),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .scale_we(scale_we), .scale_addr(scale_addr),
    .weight_we(weight_we), .weight_addr(weight_addr),
    .bias_we(bias_we), .bias_addr(bias_addr),
    .buf_wdata(buf_wdata), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [3:0] st);
    state   = st;
    s_valid = 1'b0;
    @(negedge clk);
    check_val("rdy_entry", 64'(s_ready), 64'd0);
    tick();
  endtask

  task automatic gap(input logic exp_rdy);
    s_valid = 1'b0;
    @(negedge clk);
    check_val("rdy_gap", 64'(s_ready), 64'(exp_rdy));
    tick();
  endtask

  task automatic expect_err(input logic exp);
    @(negedge clk);
    check_val("load_err", 64'(load_err), 64'(exp));
    tick();
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic acc,
                      input logic [2:0] we, input logic [12:0] addr, input logic done);
    wr_t e;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    check_val("s_ready", 64'(s_ready), 64'(acc));
    if (acc) begin
      e.we = we; e.addr = addr; e.data = d; e.done = done;
      exp_q.push_back(e);
      if (done) exp_done++;
    end
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    check_val({tag, "_flags"}, 64'({s_ready, scale_we, weight_we, bias_we, load_done, load_err}), 64'd0);
    check_val({tag, "_addr"}, 64'({scale_addr, weight_addr, bias_addr}), 64'd0);
    check_val({tag, "_wdata"}, 64'(buf_wdata), 64'd0);
    tick();
  endtask

  // write monitor: every buffer write must match the head of the scoreboard
  always @(negedge clk) begin
    logic [2:0]  we_v;
    logic [12:0] a;
    wr_t         e;
    we_v = {scale_we, weight_we, bias_we};
    if (we_v != 3'b000) begin
      if (exp_q.size() == 0) begin
        check_val("unexp_write", 64'(we_v), 64'd0);
      end else begin
        e = exp_q.pop_front();
        a = scale_we ? 13'(scale_addr) : (weight_we ? 13'(weight_addr) : 13'(bias_addr));
        check_val("we_sel", 64'(we_v), 64'(e.we));
        check_val("addr", 64'(a), 64'(e.addr));
        check_val("wdata", 64'(buf_wdata), 64'(e.data));
        check_val("done_w", 64'(load_done), 64'(e.done));
      end
    end else begin
      check_val("done_idle", 64'(load_done), 64'(lone_done_exp));
    end
    if (load_done) done_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; state = IDLE; s_valid = 1'b0; s_data = 32'd0; s_last = 1'b0;
    cfg_scale_len = 9'd4; cfg_weight_len = 13'd6; cfg_bias_len = 9'd0;
    tick(); tick();
    check_zero("rst");
    rstn = 1'b1;
    tick();

    // scale, len 4, back-to-back
    enter(RECEIVE_SCALE);
    for (int i = 0; i < 4; i++)
      send(32'hA0 + 32'(i), (i == 3), 1'b1, WE_S, 13'(i), (i == 3));
    gap(1'b0);
    expect_err(1'b0);

    // weight, len 6, valid toggling; a 7th word must be refused
    state = IDLE; gap(1'b0);
    enter(RECEIVE_WEIGHT);
    for (int i = 0; i < 6; i++) begin
      send(32'hB0 + 32'(i), (i == 5), 1'b1, WE_W, 13'(i), (i == 5));
      if (i < 5) gap(1'b1);
    end
    gap(1'b0);
    send(32'hBF, 1'b0, 1'b0, WE_W, 13'd6, 1'b0);
    gap(1'b0);

    // bias, len 0: done on the cycle after entry, never ready
    state = IDLE; gap(1'b0);
    enter(RECEIVE_BIAS);
    lone_done_exp = 1'b1; exp_done++;
    gap(1'b0);
    lone_done_exp = 1'b0;
    gap(1'b0); gap(1'b0);

    // scale, len 3, early s_last: error is sticky until IDLE
    state = IDLE; cfg_scale_len = 9'd3; gap(1'b0);
    enter(RECEIVE_SCALE);
    send(32'hC0, 1'b0, 1'b1, WE_S, 13'd0, 1'b0);
    send(32'hC1, 1'b1, 1'b1, WE_S, 13'd1, 1'b0);
    send(32'hC2, 1'b0, 1'b1, WE_S, 13'd2, 1'b1);
    expect_err(1'b1);
    expect_err(1'b1);
    state = IDLE;
    expect_err(1'b1);
    expect_err(1'b0);

    // weight len 8 switched to bias len 2 after 3 words
    cfg_weight_len = 13'd8; cfg_bias_len = 9'd2;
    enter(RECEIVE_WEIGHT);
    for (int i = 0; i < 3; i++)
      send(32'hD0 + 32'(i), 1'b0, 1'b1, WE_W, 13'(i), 1'b0);
    state = RECEIVE_BIAS;
    send(32'hDF, 1'b0, 1'b0, WE_B, 13'd0, 1'b0);
    send(32'hE0, 1'b0, 1'b1, WE_B, 13'd0, 1'b0);
    send(32'hE1, 1'b1, 1'b1, WE_B, 13'd1, 1'b1);
    gap(1'b0);
    expect_err(1'b0);

    // reset after 2 of 5 scale words, then restart from address 0
    state = IDLE; cfg_scale_len = 9'd5; gap(1'b0);
    enter(RECEIVE_SCALE);
    send(32'h50, 1'b0, 1'b1, WE_S, 13'd0, 1'b0);
    send(32'h51, 1'b0, 1'b1, WE_S, 13'd1, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check_zero("rst_mid");
    for (int i = 0; i < 5; i++)
      send(32'h60 + 32'(i), (i == 4), 1'b1, WE_S, 13'(i), (i == 4));
    gap(1'b0);
    expect_err(1'b0);

    state = IDLE;
    gap(1'b0); gap(1'b0);
    check_val("q_empty", 64'(exp_q.size()), 64'd0);
    check_val("done_count", 64'(done_cnt), 64'(exp_done));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
